sram_fifo_ctrl: RTL

Controller that turns the 32-entry two-bank 1R1W SRAM wrapper into a synchronous valid/ready FIFO. It is the initiator on the memory's write and read ports: it owns the write and read pointers, tracks occupancy, and absorbs the SRAM's one-cycle read latency with a 2-entry output buffer. It sits between a streaming producer and consumer in the same clock domain.

---
 rtl/sram_fifo_pkg.sv | 15 +
 rtl/sram_fifo_obuf.sv | 64 ++++++
 rtl/sram_fifo_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed valid/ready FIFO controller.
package sram_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int RAM_DEPTH_DEF  = 32;

  // Depth of the registered output buffer that hides the SRAM read latency.
  localparam int OBUF_DEPTH = 2;

  // The SRAM wrapper selects its read bank with the pointer MSB.
  function automatic int bank_bit(input int addr_width);
    return addr_width - 1;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry registered output buffer; head entry drives the consumer data directly.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [1:0]            cnt_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;

  // Next-state: entry 0 is always the oldest word, entry 1 the one behind it.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = data_i;
        else               ent1_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          ent0_d = data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = data_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; the head is cleared on reset so the output reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = ent0_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller over a two-bank 1R1W SRAM with one-cycle read latency.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_wpointer,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_rpointer,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int MSB     = bank_bit(ADDR_WIDTH);
  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int COUNT_W = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0] MEM_FULL = CNT_W'(RAM_DEPTH);
  localparam logic [2:0]       OB_MAX   = 3'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;

  logic       push, pop, issue, room, bank_ok;
  logic [1:0] ob_cnt;
  logic [2:0] slots_used;

  // Handshakes; readiness looks only at registered SRAM occupancy.
  assign s_ready = !rst && (mem_cnt_q != MEM_FULL);
  assign m_valid = (ob_cnt != 2'd0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // A read may issue only if its word is guaranteed a buffer slot on capture,
  // and, while a capture is pending, only from the bank whose data is returning.
  assign slots_used = {1'b0, ob_cnt} + {2'b0, inflight_q};
  assign room       = slots_used < (OB_MAX + {2'b0, pop});
  assign bank_ok    = !inflight_q || (rptr_q[MSB] == inflight_addr_q[MSB]);
  assign issue      = (mem_cnt_q != '0) && room && bank_ok;

  // SRAM port drive; an idle read port holds the last address so the bank mux stays put.
  assign mem_wen      = push;
  assign mem_wpointer = wptr_q;
  assign mem_wdata    = s_data;
  assign mem_ren      = issue;
  assign mem_rpointer = issue ? rptr_q : inflight_addr_q;

  // Pointer, occupancy and in-flight tracking next-state.
  always_comb begin
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    inflight_addr_d = inflight_addr_q;
    inflight_d      = issue;
    mem_cnt_d       = mem_cnt_q + CNT_W'(push) - CNT_W'(issue);
    if (push) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (issue) begin
      rptr_d          = rptr_q + ADDR_WIDTH'(1);
      inflight_addr_d = rptr_q;
    end
  end

  // Control state; reset also discards any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      mem_cnt_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      mem_cnt_q       <= mem_cnt_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  // Read data is captured into the output buffer the cycle after issue.
  sram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .data_i (mem_rdata),
    .pop_i  (pop),
    .cnt_o  (ob_cnt),
    .head_o (m_data)
  );

  assign count = COUNT_W'(mem_cnt_q) + COUNT_W'(inflight_q) + COUNT_W'(ob_cnt);

endmodule
